w_word_loader: RTL

// Serial front end feeding the W decoder: shifts in a 16-bit frame over a 3-wire serial link (sclk/sdata/cs_n),

---
 rtl/w_word_loader_pkg.sv | 29 ++
 rtl/w_word_loader_serial_sync_edge.sv | 30 +++
 rtl/w_word_loader.sv | 135 +++++++++++++
 3 files changed

// File: rtl/w_word_loader_pkg.sv
// Shared constants, FSM state type and frame validation helper for the W word loader.
package w_word_loader_pkg;

    localparam int FRAME_BITS  = 16;
    localparam int W_WIDTH     = 13;
    localparam int CMD_BITS    = FRAME_BITS - W_WIDTH;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 5;

    localparam logic [CMD_BITS-1:0] CMD_LOAD = 3'b101;
    localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(FRAME_BITS + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CHECK,
        ST_WAIT_DONE,
        ST_ISSUE
    } w_state_e;

    // A frame is accepted only with the exact length, the load command and a nonzero payload.
    function automatic logic frame_valid(input logic [FRAME_BITS-1:0] frame,
                                         input logic [CNT_W-1:0]      count);
        return (count == CNT_W'(FRAME_BITS)) &&
               (frame[FRAME_BITS-1:W_WIDTH] == CMD_LOAD) &&
               (frame[W_WIDTH-1:0] != '0);
    endfunction

endpackage

// File: rtl/w_word_loader_serial_sync_edge.sv
// Multi-stage synchronizer for one asynchronous input with change detection on the
// last two synchronized samples; level plus change gives rise and fall.
module serial_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync_out,
    output logic chg
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign sync_out = chain[STAGES-1];
    assign chg      = chain[STAGES-1] ^ prev;

endmodule

// File: rtl/w_word_loader.sv
// Serial front end for the W decoder: synchronizes the 3-wire link, shifts in a frame,
// validates it and hands the W word to the decoder with a one-cycle dec_start strobe.
module w_word_loader
    import w_word_loader_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               sclk,
    input  logic               sdata,
    input  logic               cs_n,
    input  logic               dec_done,
    output logic [W_WIDTH-1:0] W,
    output logic               dec_start,
    output logic               frame_ok,
    output logic               frame_err,
    output logic               busy,
    output w_state_e           fsm_state
);

    logic sclk_s, sclk_chg, sclk_rise;
    logic cs_s, cs_chg, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] sdata_chain;
    logic sdata_s;

    w_state_e               state;
    logic [FRAME_BITS-1:0]  shreg;
    logic [CNT_W-1:0]       cnt;
    logic [W_WIDTH-1:0]     pending;

    serial_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk_sync (
        .clk      (clk),
        .reset    (reset),
        .din      (sclk),
        .sync_out (sclk_s),
        .chg      (sclk_chg)
    );

    serial_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk      (clk),
        .reset    (reset),
        .din      (cs_n),
        .sync_out (cs_s),
        .chg      (cs_chg)
    );

    // sdata only needs the chain; it is sampled when the aligned sclk rise is seen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sdata_chain <= '0;
        end else begin
            sdata_chain <= {sdata_chain[SYNC_STAGES-2:0], sdata};
        end
    end

    assign sdata_s   = sdata_chain[SYNC_STAGES-1];
    assign sclk_rise = sclk_chg & sclk_s;
    assign cs_rise   = cs_chg & cs_s;
    assign cs_fall   = cs_chg & ~cs_s;
    assign fsm_state = state;

    // Decoder handshake: dec_start is a one-cycle request issued only while dec_done is
    // high; dec_done low means the decoder is busy, so a validated word waits in
    // WAIT_DONE until dec_done returns high. There is no backpressure on the serial side:
    // the link master watches busy and must not start a frame while it is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            W         <= '0;
            pending   <= '0;
            shreg     <= '0;
            cnt       <= '0;
            dec_start <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            dec_start <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state <= ST_SHIFT;
                        cnt   <= '0;
                        shreg <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (cs_fall) begin
                        cnt   <= '0;
                        shreg <= '0;
                    end else begin
                        // A bit arriving together with the closing cs_n edge still counts.
                        if (sclk_rise) begin
                            shreg <= {shreg[FRAME_BITS-2:0], sdata_s};
                            if (cnt != CNT_MAX) begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                        if (cs_rise) begin
                            state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (frame_valid(shreg, cnt)) begin
                        pending <= shreg[W_WIDTH-1:0];
                        state   <= ST_WAIT_DONE;
                    end else begin
                        frame_err <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (dec_done) begin
                        W         <= pending;
                        dec_start <= 1'b1;
                        frame_ok  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
